// File: rtl/spi_reg_cmd_decoder_if.sv
// Signal bundle between the SPI byte serializer, the command decoder and the register array.
// The decoder uses the slave view; the surrounding SPI/array logic uses the master view.
interface spi_reg_cmd_decoder_if;
  logic        frame_active;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        tx_byte_valid;
  logic [7:0]  reg_addr;
  logic [15:0] reg_write_data;
  logic        reg_write_enable;
  logic        reg_read_enable;
  logic [15:0] reg_read_data;
  logic        cmd_error;

  modport slave (
    input  frame_active,
    input  rx_valid,
    input  rx_byte,
    input  tx_ready,
    input  reg_read_data,
    output tx_byte,
    output tx_byte_valid,
    output reg_addr,
    output reg_write_data,
    output reg_write_enable,
    output reg_read_enable,
    output cmd_error
  );

  modport master (
    output frame_active,
    output rx_valid,
    output rx_byte,
    output tx_ready,
    output reg_read_data,
    input  tx_byte,
    input  tx_byte_valid,
    input  reg_addr,
    input  reg_write_data,
    input  reg_write_enable,
    input  reg_read_enable,
    input  cmd_error
  );
endinterface

// File: rtl/spi_reg_cmd_decoder.sv
// Decodes framed SPI byte streams (cmd, addr, data...) into register-array strobes and
// returns read words as MSB/LSB byte pairs, with optional burst address auto-increment.
module spi_reg_cmd_decoder #(
  parameter bit          AUTO_INC = 1'b1,
  parameter int unsigned RD_LAT   = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  spi_reg_cmd_decoder_if.slave bus
);

  localparam logic [7:0] CmdWrite = 8'h80;
  localparam logic [7:0] CmdRead  = 8'h00;
  localparam logic [7:0] AddrStep = {7'd0, AUTO_INC};
  localparam logic [7:0] RdLatCnt = 8'(RD_LAT);

  typedef enum logic [3:0] {
    StIdle,
    StCmd,
    StAddr,
    StWrMsb,
    StWrLsb,
    StRdIssue,
    StRdWait,
    StRdMsb,
    StRdLsb,
    StErr
  } state_e;

  state_e      state_q;
  logic        is_write_q;
  logic [7:0]  addr_q;
  logic [7:0]  msb_q;
  logic [15:0] rdbuf_q;
  logic [7:0]  lat_cnt_q;

  logic [7:0]  tx_byte_q;
  logic        tx_byte_valid_q;
  logic [7:0]  reg_addr_q;
  logic [15:0] reg_write_data_q;
  logic        reg_write_enable_q;
  logic        reg_read_enable_q;
  logic        cmd_error_q;

  logic [7:0]  addr_next;

  assign addr_next = addr_q + AddrStep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= StIdle;
      is_write_q         <= 1'b0;
      addr_q             <= 8'h00;
      msb_q              <= 8'h00;
      rdbuf_q            <= 16'h0000;
      lat_cnt_q          <= 8'h00;
      tx_byte_q          <= 8'h00;
      tx_byte_valid_q    <= 1'b0;
      reg_addr_q         <= 8'h00;
      reg_write_data_q   <= 16'h0000;
      reg_write_enable_q <= 1'b0;
      reg_read_enable_q  <= 1'b0;
      cmd_error_q        <= 1'b0;
    end else begin
      reg_write_enable_q <= 1'b0;
      reg_read_enable_q  <= 1'b0;
      cmd_error_q        <= 1'b0;

      // Frame end wins over everything, including a byte arriving in the same cycle.
      if (!bus.frame_active) begin
        state_q         <= StIdle;
        tx_byte_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StCmd;
          end

          StCmd: begin
            if (bus.rx_valid) begin
              if (bus.rx_byte == CmdWrite) begin
                is_write_q <= 1'b1;
                state_q    <= StAddr;
              end else if (bus.rx_byte == CmdRead) begin
                is_write_q <= 1'b0;
                state_q    <= StAddr;
              end else begin
                cmd_error_q <= 1'b1;
                state_q     <= StErr;
              end
            end
          end

          StAddr: begin
            if (bus.rx_valid) begin
              addr_q <= bus.rx_byte;
              if (is_write_q) begin
                state_q <= StWrMsb;
              end else begin
                // Strobe is registered on entry so it is high while in StRdIssue.
                reg_read_enable_q <= 1'b1;
                reg_addr_q        <= bus.rx_byte;
                state_q           <= StRdIssue;
              end
            end
          end

          StWrMsb: begin
            if (bus.rx_valid) begin
              msb_q   <= bus.rx_byte;
              state_q <= StWrLsb;
            end
          end

          StWrLsb: begin
            if (bus.rx_valid) begin
              reg_write_enable_q <= 1'b1;
              reg_addr_q         <= addr_q;
              reg_write_data_q   <= {msb_q, bus.rx_byte};
              addr_q             <= addr_next;
              state_q            <= StWrMsb;
            end
          end

          StRdIssue: begin
            lat_cnt_q <= 8'd1;
            state_q   <= StRdWait;
          end

          StRdWait: begin
            if (lat_cnt_q >= RdLatCnt) begin
              rdbuf_q         <= bus.reg_read_data;
              tx_byte_q       <= bus.reg_read_data[15:8];
              tx_byte_valid_q <= 1'b1;
              state_q         <= StRdMsb;
            end else begin
              lat_cnt_q <= lat_cnt_q + 8'd1;
            end
          end

          StRdMsb: begin
            if (bus.tx_ready) begin
              tx_byte_q <= rdbuf_q[7:0];
              state_q   <= StRdLsb;
            end else begin
              tx_byte_q <= rdbuf_q[15:8];
            end
          end

          StRdLsb: begin
            if (bus.tx_ready) begin
              tx_byte_valid_q   <= 1'b0;
              addr_q            <= addr_next;
              reg_addr_q        <= addr_next;
              reg_read_enable_q <= 1'b1;
              state_q           <= StRdIssue;
            end
          end

          StErr: begin
            state_q <= StErr;
          end

          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.tx_byte          = tx_byte_q;
  assign bus.tx_byte_valid    = tx_byte_valid_q;
  assign bus.reg_addr         = reg_addr_q;
  assign bus.reg_write_data   = reg_write_data_q;
  assign bus.reg_write_enable = reg_write_enable_q;
  assign bus.reg_read_enable  = reg_read_enable_q;
  assign bus.cmd_error        = cmd_error_q;

endmodule
